// File: rtl/keynsham_timer_array.sv
// rtl/keynsham_timer_array.sv - multi-channel prescaled down-counting timer peripheral
//
// keynsham_cs_gen: window decoder. It raises o_cs when the byte address of
// i_word_addr lies in [base, base+size).
//
// keynsham_timer_array: nr_timers independent down-counters on the keynsham bus.
//   clk, rst            clock, synchronous active-low reset
//   bus_access/bus_cs   access strobe in, window hit out (combinational)
//   bus_addr            word address: channel in [tsel+1:2], register in [1:0]
//   bus_wr_val/en/bytesel  write data, write select, byte enables
//   bus_ack/error/data  one-cycle ack after the access, error flag, read data
//   irqs                per-channel level interrupt (pending & irq_en, registered)
// Register map per channel: 0 COUNT (RO), 1 RELOAD, 2 CONTROL, 3 STATUS (W1C).

module keynsham_cs_gen #(
    parameter logic [31:0] base = 32'h0,
    parameter logic [31:0] size = 32'h0
) (
    input  logic [29:0] i_word_addr,
    output logic        o_cs
);
    logic [32:0] w_byte_addr;
    logic [32:0] w_lo;
    logic [32:0] w_hi;

    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign w_byte_addr = {1'b0, i_word_addr, 2'b00};
    assign w_lo        = {1'b0, base};
    assign w_hi        = {1'b0, base} + {1'b0, size};
    assign o_cs        = (w_byte_addr >= w_lo) && (w_byte_addr < w_hi);
endmodule

module keynsham_timer_array #(
    parameter logic [31:0] bus_address     = 32'h0,
    parameter logic [31:0] bus_size        = 32'h0,
    parameter int          nr_timers       = 4,
    parameter int          counter_width   = 32,
    parameter int          prescaler_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_access,
    output logic                 bus_cs,
    input  logic [29:0]          bus_addr,
    input  logic [31:0]          bus_wr_val,
    input  logic                 bus_wr_en,
    input  logic [3:0]           bus_bytesel,
    output logic                 bus_error,
    output logic                 bus_ack,
    output logic [31:0]          bus_data,
    output logic [nr_timers-1:0] irqs
);
    localparam int          TSEL = (nr_timers > 1) ? $clog2(nr_timers) : 1;
    localparam int          RD   = 2 ** TSEL;
    localparam int          CW   = counter_width;
    localparam int          PW   = prescaler_width;
    localparam logic [31:0] NR   = 32'(nr_timers);

    // Channel state
    logic [CW-1:0]        r_count     [nr_timers];
    logic [CW-1:0]        r_reload    [nr_timers];
    logic [PW-1:0]        r_presc_val [nr_timers];
    logic [PW-1:0]        r_presc_cnt [nr_timers];
    logic [nr_timers-1:0] r_en;
    logic [nr_timers-1:0] r_periodic;
    logic [nr_timers-1:0] r_irq_en;
    logic [nr_timers-1:0] r_pend;
    logic [nr_timers-1:0] r_irqs;

    // Bus response
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_data;

    // Next-state values
    logic [CW-1:0]        w_count_nx     [nr_timers];
    logic [CW-1:0]        w_reload_nx    [nr_timers];
    logic [PW-1:0]        w_presc_val_nx [nr_timers];
    logic [PW-1:0]        w_presc_cnt_nx [nr_timers];
    logic [nr_timers-1:0] w_sel;
    logic [nr_timers-1:0] w_en_wr;
    logic [nr_timers-1:0] w_en_nx;
    logic [nr_timers-1:0] w_periodic_nx;
    logic [nr_timers-1:0] w_irq_en_nx;
    logic [nr_timers-1:0] w_pend_nx;

    // Decode
    logic [TSEL-1:0] w_ch;
    logic [1:0]      w_reg;
    logic            w_ch_ok;
    logic            w_take;
    logic            w_err;
    logic            w_wr;
    logic [31:0]     w_mask;
    logic [31:0]     w_regs [RD][4];
    logic [31:0]     w_rd_val;
    logic [31:0]     w_merged;
    logic            w_unused;

    keynsham_cs_gen #(
        .base (bus_address),
        .size (bus_size)
    ) u_cs_gen (
        .i_word_addr (bus_addr),
        .o_cs        (bus_cs)
    );

    assign w_ch    = bus_addr[TSEL+1:2];
    assign w_reg   = bus_addr[1:0];
    assign w_ch_ok = (32'(w_ch) < NR);
    assign w_take  = bus_access & bus_cs;
    assign w_err   = !w_ch_ok || (bus_wr_en && (w_reg == 2'd0));
    assign w_wr    = w_take && bus_wr_en && !w_err;
    assign w_mask  = {{8{bus_bytesel[3]}}, {8{bus_bytesel[2]}},
                      {8{bus_bytesel[1]}}, {8{bus_bytesel[0]}}};

    // Register images, zero-padded; slots for nonexistent channels read as 0.
    always_comb begin
        for (int c = 0; c < RD; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_regs[c][r] = '0;
            end
        end
        for (int i = 0; i < nr_timers; i++) begin
            w_regs[i][0][CW-1:0]  = r_count[i];
            w_regs[i][1][CW-1:0]  = r_reload[i];
            w_regs[i][2][0]       = r_en[i];
            w_regs[i][2][1]       = r_periodic[i];
            w_regs[i][2][2]       = r_irq_en[i];
            w_regs[i][2][16 +: PW] = r_presc_val[i];
            w_regs[i][3][0]       = r_pend[i];
        end
    end

    assign w_rd_val = w_ch_ok ? w_regs[w_ch][w_reg] : '0;
    // Byte-masked merge against the current image; bits outside a field drop away.
    assign w_merged = (w_rd_val & ~w_mask) | (bus_wr_val & w_mask);
    assign w_unused = ^w_merged;

    always_comb begin
        for (int i = 0; i < nr_timers; i++) begin
            w_sel[i]          = w_wr && (w_ch == TSEL'(i));
            w_reload_nx[i]    = (w_sel[i] && (w_reg == 2'd1)) ? w_merged[CW-1:0] : r_reload[i];
            w_en_wr[i]        = r_en[i];
            w_periodic_nx[i]  = r_periodic[i];
            w_irq_en_nx[i]    = r_irq_en[i];
            w_presc_val_nx[i] = r_presc_val[i];
            if (w_sel[i] && (w_reg == 2'd2)) begin
                w_en_wr[i]        = w_merged[0];
                w_periodic_nx[i]  = w_merged[1];
                w_irq_en_nx[i]    = w_merged[2];
                w_presc_val_nx[i] = w_merged[16 +: PW];
            end
            w_count_nx[i]     = r_count[i];
            w_presc_cnt_nx[i] = r_presc_cnt[i];
            w_en_nx[i]        = w_en_wr[i];
            // W1C first; an expiry below overrides it so set wins.
            w_pend_nx[i]      = r_pend[i] &
                                ~(w_sel[i] && (w_reg == 2'd3) && bus_bytesel[0] && bus_wr_val[0]);
            if (!r_en[i] && w_en_wr[i]) begin
                w_count_nx[i]     = w_reload_nx[i];
                w_presc_cnt_nx[i] = '0;
            end else if (r_en[i]) begin
                // >= rather than == so lowering P below the running count still wraps promptly.
                if (r_presc_cnt[i] >= r_presc_val[i]) begin
                    w_presc_cnt_nx[i] = '0;
                    if (r_count[i] != '0) begin
                        w_count_nx[i] = r_count[i] - 1'b1;
                    end else begin
                        w_pend_nx[i] = 1'b1;
                        if (r_periodic[i]) begin
                            w_count_nx[i] = w_reload_nx[i];
                        end else begin
                            w_en_nx[i] = 1'b0;
                        end
                    end
                end else begin
                    w_presc_cnt_nx[i] = r_presc_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
            for (int i = 0; i < nr_timers; i++) begin
                r_count[i]     <= '0;
                r_reload[i]    <= '0;
                r_presc_val[i] <= '0;
                r_presc_cnt[i] <= '0;
            end
            r_en       <= '0;
            r_periodic <= '0;
            r_irq_en   <= '0;
            r_pend     <= '0;
            r_irqs     <= '0;
        end else begin
            r_ack  <= w_take;
            r_err  <= w_take && w_err;
            r_data <= (w_take && !w_err && !bus_wr_en) ? w_rd_val : '0;
            for (int i = 0; i < nr_timers; i++) begin
                r_count[i]     <= w_count_nx[i];
                r_reload[i]    <= w_reload_nx[i];
                r_presc_val[i] <= w_presc_val_nx[i];
                r_presc_cnt[i] <= w_presc_cnt_nx[i];
            end
            r_en       <= w_en_nx;
            r_periodic <= w_periodic_nx;
            r_irq_en   <= w_irq_en_nx;
            r_pend     <= w_pend_nx;
            r_irqs     <= r_pend & r_irq_en;
        end
    end

    assign bus_ack   = r_ack;
    assign bus_error = r_err;
    assign bus_data  = r_data;
    assign irqs      = r_irqs;
endmodule

// File: tb/tb_keynsham_timer_array.sv
// tb/tb_keynsham_timer_array.sv - directed self-checking bench for keynsham_timer_array
module tb_keynsham_timer_array;
    logic        clk = 1'b0;
    logic        rst;
    logic        access;
    logic [29:0] addr;
    logic [31:0] wv;
    logic        we;
    logic [3:0]  be;
    logic        cs_a, cs_b, ack_a, ack_b, err_a, err_b;
    logic [31:0] data_a, data_b;
    logic [2:0]  irqs_a;
    logic [0:0]  irqs_b;
    logic        back, berr;
    logic [31:0] bdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // A: 3 channels, 32-bit counters at 0x1000. B: 1 channel, 8-bit counter at 0x2000.
    keynsham_timer_array #(
        .bus_address(32'h1000), .bus_size(32'h40), .nr_timers(3),
        .counter_width(32), .prescaler_width(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus_access(access), .bus_cs(cs_a), .bus_addr(addr),
        .bus_wr_val(wv), .bus_wr_en(we), .bus_bytesel(be), .bus_error(err_a),
        .bus_ack(ack_a), .bus_data(data_a), .irqs(irqs_a)
    );

    keynsham_timer_array #(
        .bus_address(32'h2000), .bus_size(32'h10), .nr_timers(1),
        .counter_width(8), .prescaler_width(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus_access(access), .bus_cs(cs_b), .bus_addr(addr),
        .bus_wr_val(wv), .bus_wr_en(we), .bus_bytesel(be), .bus_error(err_b),
        .bus_ack(ack_b), .bus_data(data_b), .irqs(irqs_b)
    );

    assign back  = ack_a | ack_b;
    assign berr  = err_a | err_b;
    assign bdata = data_a | data_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] ra(input int ch, input int r);
        return 30'h400 + 30'(ch * 4 + r);
    endfunction

    function automatic logic [29:0] rb(input int r);
        return 30'h800 + 30'(r);
    endfunction

    // Access driven for one cycle from a falling edge; response sampled on the next falling edge.
    task automatic bus_op(input logic [29:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, output logic [31:0] rd, output logic [1:0] ae);
        @(negedge clk);
        access = 1'b1; addr = a; we = w; wv = d; be = b;
        @(negedge clk);
        access = 1'b0; we = 1'b0;
        rd = bdata;
        ae = {back, berr};
    endtask

    task automatic bus_write(input string tag, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic exp_err);
        logic [31:0] rd;
        logic [1:0]  ae;
        bus_op(a, 1'b1, d, b, rd, ae);
        check({tag, "/ack_err"}, 32'(ae), {30'b0, 1'b1, exp_err});
    endtask

    task automatic bus_read(input string tag, input logic [29:0] a, input logic exp_err,
                            input logic [31:0] exp);
        logic [31:0] rd;
        logic [1:0]  ae;
        bus_op(a, 1'b0, 32'h0, 4'h0, rd, ae);
        check({tag, "/ack_err"}, 32'(ae), {30'b0, 1'b1, exp_err});
        check(tag, rd, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_cnt [8];
        int exp_irq [8];
        exp_cnt = '{3, 2, 1, 0, 3, 2, 1, 0};
        exp_irq = '{0, 0, 0, 0, 1, 1, 1, 1};

        rst = 1'b0; access = 1'b0; addr = '0; wv = '0; we = 1'b0; be = 4'h0;

        // 1: reset with random traffic, including writes that must be dropped
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("reset_resp[%0d]", k), {26'b0, back, berr, irqs_a, irqs_b}, 32'h0);
            check($sformatf("reset_data[%0d]", k), bdata, 32'h0);
            access = 1'($urandom_range(0, 1));
            addr   = ($urandom_range(0, 1) == 1) ? (30'h400 + 30'($urandom_range(0, 15)))
                                                 : (30'h800 + 30'($urandom_range(0, 3)));
            we     = 1'($urandom_range(0, 1));
            wv     = $urandom;
            be     = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        access = 1'b0; we = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("post_reset_ack", 32'(back), 32'h0);

        addr = 30'h400; #1 check("cs_a_hit", {30'b0, cs_a, cs_b}, 32'h2);
        addr = 30'h800; #1 check("cs_b_hit", {30'b0, cs_a, cs_b}, 32'h1);
        addr = 30'h000; #1 check("cs_miss",  {30'b0, cs_a, cs_b}, 32'h0);

        for (int c = 0; c < 3; c++) begin
            bus_read($sformatf("rst_reload_ch%0d", c), ra(c, 1), 1'b0, 32'h0);
            bus_read($sformatf("rst_ctrl_ch%0d", c),   ra(c, 2), 1'b0, 32'h0);
        end
        bus_read("rst_b_count", rb(0), 1'b0, 32'h0);

        // 2: ch0 periodic, RELOAD=3, P=0, irq enabled
        bus_write("ch0_reload", ra(0, 1), 32'd3, 4'hf, 1'b0);
        bus_write("ch0_ctrl",   ra(0, 2), 32'h7, 4'hf, 1'b0);
        access = 1'b1; addr = ra(0, 0); we = 1'b0; be = 4'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("ch0_count[%0d]", k), bdata, 32'(exp_cnt[k]));
            check($sformatf("ch0_irq[%0d]", k), 32'(irqs_a[0]), 32'(exp_irq[k]));
        end
        access = 1'b0;

        // 3: ch2 one-shot, RELOAD=2, P=4 -> expiry on the 15th clock after enable
        bus_write("ch2_reload", ra(2, 1), 32'd2, 4'hf, 1'b0);
        bus_write("ch2_ctrl",   ra(2, 2), 32'h0004_0001, 4'hf, 1'b0);
        repeat (13) @(negedge clk);
        bus_read("ch2_status_before", ra(2, 3), 1'b0, 32'h0);
        bus_read("ch2_status_after",  ra(2, 3), 1'b0, 32'h1);
        bus_read("ch2_ctrl_disabled", ra(2, 2), 1'b0, 32'h0004_0000);
        bus_read("ch2_count_zero",    ra(2, 0), 1'b0, 32'h0);
        check("ch2_irq_off", 32'(irqs_a[2]), 32'h0);
        repeat (40) @(negedge clk);
        bus_write("ch2_w1c", ra(2, 3), 32'h1, 4'h1, 1'b0);
        repeat (20) @(negedge clk);
        bus_read("ch2_no_reexpiry", ra(2, 3), 1'b0, 32'h0);

        // 5: ch1 RELOAD=0 periodic expires every clock, so any W1C collides with an expiry
        bus_write("ch1_ctrl_on", ra(1, 2), 32'h7, 4'hf, 1'b0);
        repeat (3) @(negedge clk);
        bus_write("ch1_w1c_collide", ra(1, 3), 32'h1, 4'h1, 1'b0);
        bus_read("ch1_set_wins", ra(1, 3), 1'b0, 32'h1);
        check("ch1_irq_on", 32'(irqs_a[1]), 32'h1);
        bus_write("ch1_ctrl_off", ra(1, 2), 32'h4, 4'hf, 1'b0);
        bus_read("ch1_pend_kept", ra(1, 3), 1'b0, 32'h1);
        bus_write("ch1_w1c", ra(1, 3), 32'h1, 4'h1, 1'b0);
        check("ch1_irq_lag", 32'(irqs_a[1]), 32'h1);
        @(negedge clk);
        check("ch1_irq_drop", 32'(irqs_a[1]), 32'h0);
        bus_read("ch1_pend_clear", ra(1, 3), 1'b0, 32'h0);

        // 4: error cases and byte enables
        bus_read("ch3_read_err", ra(3, 0), 1'b1, 32'h0);
        bus_write("ch3_write_err", ra(3, 1), 32'h1234, 4'hf, 1'b1);
        bus_write("ch2_count_wr_err", ra(2, 0), 32'h55, 4'hf, 1'b1);
        bus_read("ch2_count_unchanged", ra(2, 0), 1'b0, 32'h0);
        bus_write("ch1_reload_byte1", ra(1, 1), 32'hAABB_CCDD, 4'b0010, 1'b0);
        bus_read("ch1_reload_masked", ra(1, 1), 1'b0, 32'h0000_CC00);

        // 6: 8-bit counter instance
        bus_write("b_reload_wide", rb(1), 32'h1FF, 4'hf, 1'b0);
        bus_read("b_reload_trunc", rb(1), 1'b0, 32'hFF);
        bus_write("b_reload", rb(1), 32'h10, 4'hf, 1'b0);
        bus_write("b_ctrl_on", rb(2), 32'h3, 4'hf, 1'b0);
        repeat (3) @(negedge clk);
        bus_write("b_ctrl_off", rb(2), 32'h2, 4'hf, 1'b0);
        bus_read("b_count_frozen", rb(0), 1'b0, 32'h0B);
        repeat (5) @(negedge clk);
        bus_read("b_count_still", rb(0), 1'b0, 32'h0B);
        bus_write("b_ctrl_reon", rb(2), 32'h3, 4'hf, 1'b0);
        bus_read("b_count_reloaded", rb(0), 1'b0, 32'h0F);
        check("b_irq_off", 32'(irqs_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
